// File: rtl/link_bert_if.sv
// Bundle of the BERT sequencer's control, transmitter-side and receiver-side signals.
interface link_bert_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             abort;
    logic             tx_data;
    logic             tx_we;
    logic             tx_full;
    logic             rx_data;
    logic             rx_valid;
    logic             rx_lock;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [CNT_W-1:0] tx_count;
    logic [CNT_W-1:0] rx_count;
    logic [CNT_W-1:0] err_count;

    // Run requester / link side: issues commands, feeds FIFO status and receiver data.
    modport master (
        output start, abort, tx_full, rx_data, rx_valid, rx_lock,
        input  tx_data, tx_we, busy, done, pass, timeout, tx_count, rx_count, err_count
    );

    // The sequencer itself.
    modport slave (
        input  start, abort, tx_full, rx_data, rx_valid, rx_lock,
        output tx_data, tx_we, busy, done, pass, timeout, tx_count, rx_count, err_count
    );
endinterface

// File: rtl/link_bert_controller.sv
// Bit-error-rate test sequencer: pushes a PRBS-15 payload into the transmitter,
// aligns a reference PRBS to the receiver output and counts bits and errors.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; counters hold last values
// PRESKIP | advancing reference LFSR past bits eaten by receiver lock
// RUN     | transmitting payload and comparing received bits
// DONE    | run finished; pass/timeout valid, held until start/abort
module link_bert_controller #(
    parameter int unsigned BITS_NUMB      = 200,
    parameter int unsigned SKIP_BITS      = 64,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned ERR_THRESH     = 0,
    parameter logic [14:0] PRBS_SEED      = 15'h7FFF,
    parameter int unsigned CNT_W          = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    link_bert_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESKIP = 2'd1,
        S_RUN     = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_BITS      = CNT_W'(BITS_NUMB);
    localparam logic [CNT_W-1:0] C_RX_TARGET = CNT_W'(BITS_NUMB - SKIP_BITS);
    localparam logic [CNT_W-1:0] C_TIMEOUT   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] C_ERR_LIM   = CNT_W'(ERR_THRESH);
    // Only meaningful when SKIP_BITS > 0; with zero skip PRESKIP is bypassed.
    localparam logic [CNT_W-1:0] C_SKIP_LAST = CNT_W'(SKIP_BITS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [14:0]      r_tx_lfsr;
    logic [14:0]      r_ref_lfsr;
    logic [CNT_W-1:0] r_tx_count;
    logic [CNT_W-1:0] r_rx_count;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_cyc_count;
    logic [CNT_W-1:0] r_skip_count;
    logic             r_pass;
    logic             r_timeout;

    logic             w_load;
    logic             w_tx_we;
    logic             w_rx_take;
    logic             w_finish;
    logic             w_timeout_hit;

    // PRBS-15, x^15 + x^14 + 1, output taken from bit 14.
    function automatic logic [14:0] prbs_next(input logic [14:0] s);
        return {s[13:0], s[14] ^ s[13]};
    endfunction

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle strobes; abort overrides everything.
    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_tx_we       = 1'b0;
        w_rx_take     = 1'b0;
        w_finish      = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = (SKIP_BITS == 0) ? S_RUN : S_PRESKIP;
                end
            end
            S_PRESKIP: begin
                if (r_skip_count == C_SKIP_LAST) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_tx_we   = (r_tx_count < C_BITS) && !bus.tx_full;
                w_rx_take = bus.rx_valid && bus.rx_lock && (r_rx_count < C_RX_TARGET);
                // Completion is checked first so it wins a tie with the timeout.
                if (r_rx_count == C_RX_TARGET) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_cyc_count >= C_TIMEOUT) begin
                    w_timeout_hit = 1'b1;
                    w_state_nxt   = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.abort) begin
            // Write strobe is suppressed so the held tx_count matches what the FIFO received.
            w_state_nxt   = S_IDLE;
            w_load        = 1'b0;
            w_tx_we       = 1'b0;
            w_rx_take     = 1'b0;
            w_finish      = 1'b0;
            w_timeout_hit = 1'b0;
        end
    end

    // LFSRs, counters and result flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_lfsr    <= '0;
            r_ref_lfsr   <= '0;
            r_tx_count   <= '0;
            r_rx_count   <= '0;
            r_err_count  <= '0;
            r_cyc_count  <= '0;
            r_skip_count <= '0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
        end else if (bus.abort) begin
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_load) begin
            r_tx_lfsr    <= PRBS_SEED;
            r_ref_lfsr   <= PRBS_SEED;
            r_tx_count   <= '0;
            r_rx_count   <= '0;
            r_err_count  <= '0;
            r_cyc_count  <= '0;
            r_skip_count <= '0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            if (r_state == S_PRESKIP) begin
                r_ref_lfsr   <= prbs_next(r_ref_lfsr);
                r_skip_count <= r_skip_count + 1'b1;
            end
            if (((r_state == S_PRESKIP) || (r_state == S_RUN)) && (r_cyc_count != '1)) begin
                r_cyc_count <= r_cyc_count + 1'b1;
            end
            if (w_tx_we) begin
                r_tx_lfsr  <= prbs_next(r_tx_lfsr);
                r_tx_count <= r_tx_count + 1'b1;
            end
            if (w_rx_take) begin
                r_ref_lfsr <= prbs_next(r_ref_lfsr);
                r_rx_count <= r_rx_count + 1'b1;
                if (bus.rx_data != r_ref_lfsr[14]) begin
                    r_err_count <= r_err_count + 1'b1;
                end
            end
            if (w_finish) begin
                r_timeout <= 1'b0;
                r_pass    <= (r_err_count <= C_ERR_LIM);
            end
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
                r_pass    <= 1'b0;
            end
        end
    end

    // tx_data is forced low outside RUN so the FIFO input is quiet while idle or in reset.
    assign bus.tx_data   = (r_state == S_RUN) & r_tx_lfsr[14];
    assign bus.tx_we     = w_tx_we;
    assign bus.busy      = (r_state == S_PRESKIP) || (r_state == S_RUN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.pass      = r_pass;
    assign bus.timeout   = r_timeout;
    assign bus.tx_count  = r_tx_count;
    assign bus.rx_count  = r_rx_count;
    assign bus.err_count = r_err_count;

endmodule

// File: doc/link_bert_controller.md
# link_bert_controller

Synthesizable bit-error-rate test sequencer for the transmitter → channel → receiver link. It replaces the simulation-only data generator and checker with on-chip logic. It generates a PRBS payload into the transmitter input FIFO and aligns a local reference PRBS to the receiver output. It then counts transmitted bits, received bits and bit errors, and reports pass/fail/timeout for a single run.

## Interface
- BITS_NUMB, 200: payload bits pushed into the transmitter per run.
- SKIP_BITS, 64: payload bits consumed by receiver lock acquisition. Receiver bit 0 equals transmitted bit SKIP_BITS. Must be < BITS_NUMB.
- TIMEOUT_CYCLES, 50000: run length limit in clk cycles, counted from `start` acceptance.
- ERR_THRESH, 0: maximum error count that still yields pass.
- PRBS_SEED, 15'h7FFF: nonzero seed for both LFSRs (PRBS-15, x^15+x^14+1).
- CNT_W, 16: counter width. Must hold BITS_NUMB and TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle run request; honoured only in IDLE or DONE.
- abort  in  1  forces IDLE from any state; counters hold their values.
- tx_data  out  1  payload bit to transmitter `data_in`.
- tx_we  out  1  write strobe to transmitter `data_in_we`.
- tx_full  in  1  transmitter `data_in_full`.
- rx_data  in  1  receiver `data_out`.
- rx_valid  in  1  receiver `data_out_valid`.
- rx_lock  in  1  receiver `frame_sync_lock`.
- busy  out  1  high in PRESKIP and RUN.
- done  out  1  high in DONE.
- pass  out  1  valid when done.
- timeout  out  1  valid when done.
- tx_count  out  CNT_W  bits written to the transmitter.
- rx_count  out  CNT_W  received bits compared.
- err_count  out  CNT_W  mismatches.

## Operation
- FSM states: IDLE, PRESKIP, RUN, DONE.
- IDLE or DONE + `start`:
  - clear all counters, `pass` and `timeout`;
  - load both LFSRs with PRBS_SEED;
  - go to PRESKIP.
- PRESKIP:
  - advance the reference LFSR once per cycle for SKIP_BITS cycles, then go to RUN;
  - `tx_we` = 0; rx inputs ignored.
- RUN, transmit side:
  - `tx_we` = (tx_count < BITS_NUMB) && !tx_full, combinational;
  - `tx_data` = tx LFSR output bit (LFSR bit 14);
  - on each clk edge with `tx_we`=1: advance tx LFSR, tx_count +1.
- RUN, receive side:
  - on each edge with rx_valid && rx_lock: compare rx_data against reference bit, err_count +1 on mismatch, rx_count +1, advance reference LFSR;
  - rx_valid while rx_lock=0 is discarded; reference does not advance.
- RUN exit:
  - rx_count reaches BITS_NUMB−SKIP_BITS → DONE, `timeout`=0;
  - else cycle counter reaches TIMEOUT_CYCLES → DONE, `timeout`=1;
  - if both occur in the same cycle, completion wins (`timeout`=0).
- DONE:
  - `pass` = !timeout && err_count ≤ ERR_THRESH, registered on entry;
  - outputs hold until `start`, `abort` or reset.
- `abort` has priority over `start` and all transitions. It goes to IDLE, clears `pass`/`timeout`, holds counters.
- `start` during PRESKIP/RUN is ignored.
- Counters do not wrap: tx_count stops at BITS_NUMB; rx/err stop at the completion count.

## Timing
- Reset (reset_n=0, asynchronous):
  - state IDLE;
  - all counters 0;
  - tx_data, tx_we, busy, done, pass, timeout all 0.
- Release is synchronous to the next clk edge.
- `start` sampled at edge N → PRESKIP from N+1, busy=1 at N+1.
- First possible `tx_we` is edge N+1+SKIP_BITS (SKIP_BITS=0 → N+1).
- tx_full → tx_we: zero-cycle combinational path. No write is issued while full.
- rx compare and counter update take effect at the same edge the rx bit is sampled. Counters are visible one cycle later.
- Final rx bit sampled at edge M → done=1, busy=0, pass valid at M+1.
- The timeout counter starts at PRESKIP entry. With TIMEOUT_CYCLES=T, done=1 at start+T+1.

## Test plan
- Loopback model (tx_data → shift delay 40 cycles → rx; first 64 bits dropped; rx_lock=1), defaults → tx_count=200, rx_count=136, err_count=0, done=1, pass=1, timeout=0.
- Same loopback, flip received bits 10, 50, 100 → err_count=3, pass=0; repeat with ERR_THRESH=3 → pass=1.
- tx_full held high for 100 cycles starting at tx_count=30 → tx_we=0 throughout, tx_count frozen at 30, then resumes; final err_count=0, tx_count=200.
- rx_lock=0 throughout, rx_valid toggling, TIMEOUT_CYCLES=1000 → rx_count=0, done=1 at start+1001, timeout=1, pass=0.
- reset_n low mid-RUN (tx_count=120) → all outputs 0 immediately without a clock edge; after release plus `start`, full run passes.
- `abort` at tx_count=50 → IDLE next cycle, counters hold 50/…; `start` pulses during RUN are ignored (counters unaffected).
